fft_frame_sink: RTL and testbench

Output-side frame buffer for `fft_computer`. It accepts one complex result word per cycle from the core's valid/ready output port and stores a full N-point frame. It then replays the frame in natural bin order to a downstream consumer such as a host interface or display path. It is the receiving end of the core's output handshake and provides the order correction and rate decoupling the core itself does not.

---
 rtl/fft_frame_sink.sv | 165 ++++++++++++++++
 tb/tb_fft_frame_sink.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sink.sv
//------------------------------------------------------------------------------
// Module      : fft_frame_sink
// Description : Output-side frame buffer for fft_computer. It collects one
//               N-point frame from the core's valid/ready output port, then
//               replays the frame to a downstream consumer over a second
//               valid/ready port. Fill and drain alternate and never overlap.
//               Optional feature macro: FFT_SINK_BITREV_EN. When it is
//               defined, the write address is the bit-reversal of the arrival
//               index, so the core's bit-reversed output comes out in natural
//               bin order.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fft_frame_sink #(
  parameter int LOG2N = 4,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_data_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_data_ready,
  output logic          o_data_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_data_ready,
  output logic          o_frame_done,
  output logic [7:0]    o_frame_cnt
);

  localparam int               c_depth = 1 << LOG2N;
  localparam logic [LOG2N-1:0] c_zero  = '0;
  localparam logic [LOG2N-1:0] c_one   = LOG2N'(1);
  localparam logic [LOG2N-1:0] c_last  = LOG2N'(c_depth - 1);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [DW-1:0]    data_q, data_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  // Frame storage; deliberately not reset, a reset only discards the frame.
  logic [DW-1:0]    mem_q [c_depth];

  logic             w_accept;
  logic             w_xfer;
  logic             w_wr_en;
  logic [LOG2N-1:0] w_waddr;
  logic [LOG2N-1:0] w_rd_next;

  assign w_accept  = (state_q == ST_FILL) & ready_q & i_data_valid;
  assign w_xfer    = (state_q == ST_DRAIN) & valid_q & i_data_ready;
  // A word offered on the same edge that reset is sampled must not land.
  assign w_wr_en   = w_accept & i_rst_n;
  assign w_rd_next = rd_cnt_q + c_one;

`ifdef FFT_SINK_BITREV_EN
  // Store arrival index k at the bit-reversed address so that a linear
  // read-out yields natural bin order.
  for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
    assign w_waddr[gi] = wr_cnt_q[LOG2N-1-gi];
  end
`else
  assign w_waddr = wr_cnt_q;
`endif

  // Next-state and registered-output computation for the fill/drain FSM.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    data_d      = data_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_FILL: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        if (w_accept) begin
          wr_cnt_d = wr_cnt_q + c_one;
          if (wr_cnt_q == c_last) begin
            // The final write never targets address 0 (reverse of all-ones
            // is all-ones), so mem_q[0] already holds its word here.
            state_d  = ST_DRAIN;
            wr_cnt_d = c_zero;
            ready_d  = 1'b0;
            valid_d  = 1'b1;
            data_d   = mem_q[c_zero];
          end
        end
      end

      ST_DRAIN: begin
        ready_d = 1'b0;
        valid_d = 1'b1;
        if (w_xfer) begin
          rd_cnt_d = w_rd_next;
          data_d   = mem_q[w_rd_next];
          if (rd_cnt_q == c_last) begin
            state_d     = ST_FILL;
            rd_cnt_d    = c_zero;
            ready_d     = 1'b1;
            valid_d     = 1'b0;
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State, counters and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_FILL;
      wr_cnt_q    <= c_zero;
      rd_cnt_q    <= c_zero;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= '0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Buffer write port, enabled only on an accepted upstream word.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      mem_q[w_waddr] <= i_data;
    end
  end

  assign o_data_ready = ready_q;
  assign o_data_valid = valid_q;
  assign o_data       = data_q;
  assign o_frame_done = done_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sink.sv
//------------------------------------------------------------------------------
// Module      : tb_fft_frame_sink
// Description : Self-checking bench for fft_frame_sink with N=8. Frames are
//               fed with assorted upstream valid patterns and drained with
//               assorted downstream ready patterns; the expected replay order
//               comes from a reference that maps output position to arrival
//               index (identity, or bit reversal when FFT_SINK_BITREV_EN is
//               defined).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fft_frame_sink;

  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int DW    = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_data_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_data_ready = 1'b0;
  logic          o_data_ready;
  logic          o_data_valid;
  logic [DW-1:0] o_data;
  logic          o_frame_done;
  logic [7:0]    o_frame_cnt;

  int total = 0;
  int bad   = 0;
  int exp_frames = 0;
  logic [31:0] frame_w [N];

  always #5 i_clk = ~i_clk;

  fft_frame_sink #(.LOG2N(LOG2N), .DW(DW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data_valid(i_data_valid),
    .i_data      (i_data),
    .o_data_ready(o_data_ready),
    .o_data_valid(o_data_valid),
    .o_data      (o_data),
    .i_data_ready(i_data_ready),
    .o_frame_done(o_frame_done),
    .o_frame_cnt (o_frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int rev(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Arrival index of the word expected at output position i.
  function automatic int out_src(input int i);
`ifdef FFT_SINK_BITREV_EN
    return rev(i);
`else
    return i;
`endif
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_data_ready, 0);
    chk({tag, "_valid"}, o_data_valid, 0);
    chk({tag, "_data"},  o_data, 0);
    chk({tag, "_done"},  o_frame_done, 0);
    chk({tag, "_cnt"},   o_frame_cnt, 0);
  endtask

  // vmode: 0 always valid, 1 pattern 1,0,0,1,1,0,1, 2 random
  // rmode: 0 always ready, 1 toggle 1,0,1,0.., 2 random
  // ndrain: transfers to perform before returning (N = complete frame)
  task automatic run_frame(input int vmode, input int rmode, input int ndrain);
    logic [6:0]  gap_pat;
    logic        v;
    logic        r;
    logic        held;
    logic [31:0] hv;
    int idx;
    int pc;
    int budget;
    int k;
    int cyc;
    gap_pat = 7'b1011001;  // bit 0 first: 1,0,0,1,1,0,1
    idx = 0;
    pc = 0;
    budget = 0;
    while (idx < N && budget < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = gap_pat[pc % 7];
        default: v = 1'($urandom_range(0, 1));
      endcase
      pc++;
      i_data_valid = v;
      i_data = v ? frame_w[idx] : $urandom;
      if (v && o_data_ready) idx++;
      step();
      budget++;
    end
    if (idx < N) chk("fill_timeout", idx, N);
    chk("ready_low_after_fill", o_data_ready, 0);
    chk("valid_after_fill", o_data_valid, 1);

    k = 0;
    cyc = 0;
    held = 1'b0;
    hv = '0;
    while (k < ndrain && cyc < 200) begin
      if (held) begin
        chk("stall_data", o_data, hv);
        chk("stall_valid", o_data_valid, 1);
      end
      if (o_data_ready) chk("ready_in_drain", o_data_ready, 0);
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      i_data_ready = r;
      // Garbage offered upstream while not ready must never be stored.
      i_data_valid = 1'($urandom_range(0, 1));
      i_data = $urandom;
      held = 1'b0;
      if (o_data_valid) begin
        if (r) begin
          chk("out_word", o_data, frame_w[out_src(k)]);
          k++;
        end else begin
          held = 1'b1;
          hv = o_data;
        end
      end else begin
        chk("drain_valid", o_data_valid, 1);
      end
      step();
      cyc++;
    end
    if (k < ndrain) chk("drain_timeout", k, ndrain);
    if (ndrain == N) begin
      exp_frames = (exp_frames + 1) % 256;
      if (rmode == 0) chk("drain_cycles", cyc, N);
      if (rmode == 1) chk("drain_cycles", cyc, 2 * N - 1);
      chk("done_pulse", o_frame_done, 1);
      chk("valid_low_after", o_data_valid, 0);
      chk("ready_high_after", o_data_ready, 1);
      chk("frame_cnt", o_frame_cnt, exp_frames);
      i_data_ready = 1'b0;
      i_data_valid = 1'b0;
      step();
      chk("done_once", o_frame_done, 0);
      chk("frame_cnt_hold", o_frame_cnt, exp_frames);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < N; i++) frame_w[i] = $urandom;
  endtask

  initial begin
    // Reset held with upstream valid asserted.
    i_rst_n = 1'b0;
    i_data_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      i_data = $urandom;
      step();
      chk_reset_outputs("rst_hold");
    end
    i_data_valid = 1'b0;
    i_rst_n = 1'b1;
    step();
    chk("ready_after_release", o_data_ready, 1);
    chk("valid_after_release", o_data_valid, 0);

    // Identity-valued frame: shows the replay order directly.
    for (int i = 0; i < N; i++) frame_w[i] = i;
    run_frame(0, 0, N);

    // Upstream gaps.
    rand_frame();
    run_frame(1, 0, N);

    // Downstream backpressure 1,0,1,0...
    rand_frame();
    run_frame(0, 1, N);

    // Random valid/ready mixes.
    for (int f = 0; f < 6; f++) begin
      rand_frame();
      run_frame(2, 2, N);
    end

    // Reset in the middle of a drain, then a fresh frame.
    rand_frame();
    run_frame(0, 0, 3);
    i_rst_n = 1'b0;
    i_data_valid = 1'b1;
    i_data = $urandom;
    step();
    chk_reset_outputs("rst_mid");
    exp_frames = 0;
    i_rst_n = 1'b1;
    i_data_valid = 1'b0;
    step();
    chk("ready_after_mid_rst", o_data_ready, 1);
    chk("cnt_after_mid_rst", o_frame_cnt, 0);
    for (int i = 0; i < N; i++) frame_w[i] = 32'h10 + i;
    run_frame(0, 0, N);

    // Run the frame counter past its wrap point.
    for (int f = 0; f < 256; f++) begin
      rand_frame();
      run_frame(f % 3, f % 3, N);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
